ifetch_axi_lite_master: RTL
===========================

// Module: ifetch_axi_lite_master
// PURPOSE
//  AXI4-Lite read-only initiator for the core's instruction-fetch path; sits between the core's fetch port and the IMEM slave.
//  Takes one fetch request at a time, issues it on AR, collects the beat on R, and holds the instruction for the core.
//  Supports flush on branch redirect: an in-flight fetch completes on AXI, but its data is discarded.
//  Sticky timeout flag for bring-up debug.
// PARAMETERS
//  ADDR_WIDTH      32    address width, fetch port and AR channel
//  DATA_WIDTH      32    instruction/data width
//  TIMEOUT_CYCLES  256   cycles spent in S_AR+S_R before o_timeout is set; 0 disables the check
// PORTS
//  clk            in   1           clock, all logic on posedge
//  resetn         in   1           reset, asynchronous, active-low
//  i_req_valid    in   1           core fetch request
//  o_req_ready    out  1           high only in S_IDLE
//  i_req_addr     in   ADDR_WIDTH  fetch PC
//  i_flush        in   1           redirect: kill the outstanding/held fetch
//  o_rsp_valid    out  1           instruction available
//  i_rsp_ready    in   1           core consumes instruction
//  o_rsp_instr    out  DATA_WIDTH  fetched instruction
//  o_rsp_addr     out  ADDR_WIDTH  PC of o_rsp_instr
//  o_timeout      out  1           sticky; set when the timeout counter expires
//  o_axi_araddr   out  ADDR_WIDTH  read address, bits[1:0] forced to 0
//  o_axi_arvalid  out  1           read address valid
//  i_axi_arready  in   1           read address ready
//  i_axi_rdata    in   DATA_WIDTH  read data
//  i_axi_rvalid   in   1           read data valid
//  o_axi_rready   out  1           read data ready
// BEHAVIOUR
//  Reset: all outputs 0 (o_req_ready=1, since S_IDLE); state S_IDLE, discard flag 0, timeout counter 0, o_timeout 0.
//  All outputs are registered except o_req_ready, which is decoded from state.
//  S_IDLE
//    i_req_valid=1 -> latch {addr[AW-1:2],2'b00} to araddr and rsp_addr; arvalid<=1; ->S_AR.
//    i_flush here is ignored; a same-cycle request is still accepted.
//  S_AR
//    arvalid and araddr held stable until i_axi_arready=1 (AXI rule: never withdrawn).
//    On arready: arvalid<=0, rready<=1, ->S_R.
//  S_R
//    rready is held 1 unconditionally; it does not wait for rvalid.
//    The slave may hold rvalid until it sees rready and may pulse rvalid for exactly 1 cycle.
//    On rvalid: capture rdata, rready<=0.
//      discard=0: rsp_valid<=1, ->S_RSP.
//      discard=1: clear discard, ->S_IDLE.
//  S_RSP
//    instr/addr held stable while o_rsp_valid=1.
//    i_rsp_ready=1 or i_flush=1: rsp_valid<=0, ->S_IDLE. Flush wins; the data is dropped.
//  Flush in S_AR/S_R sets discard; the AXI transfer still completes, and no o_rsp_valid is produced for it.
//  Flush and rvalid in the same cycle: the beat is discarded.
//  At most one outstanding transaction; no new AR before the R beat of the previous AR.
//  Latency: request accepted at edge T -> arvalid high from T+1.
//    Zero-wait slave (arready=1, rvalid in the next cycle) gives o_rsp_valid from T+3.
//  Back-to-back: after an S_RSP consume at edge E, the next request is accepted at E+1 (one idle cycle per fetch).
//  Timeout counter
//    Increments each cycle in S_AR/S_R and saturates; it clears on entry to S_IDLE.
//    Reaching TIMEOUT_CYCLES sets o_timeout (cleared only by reset). The FSM keeps waiting; no abort.
//  resetn low mid-transaction: immediate return to reset values. The slave must be reset by the same resetn.
// TESTING
//  Slave model: arready 1 cycle after arvalid; waits for rready, then rvalid for 1 cycle; mem[w]=0x1000_0000+w.
//  1 single fetch: req addr 0x0000_0010 -> araddr=0x10, rsp_valid with instr=0x1000_0004, rsp_addr=0x10; consume -> S_IDLE.
//  2 misaligned PC: req 0x0000_0013 -> araddr=0x10, rsp_addr=0x10.
//  3 back-pressure: i_rsp_ready=0 for 5 cycles -> instr/addr stable; exactly one AR handshake; consumed on the 6th cycle.
//  4 flush in S_R: req 0x20, flush while waiting for rvalid -> R beat taken, no rsp_valid; next req 0x40 returns 0x1000_0010.
//  5 flush in S_RSP with i_rsp_ready=1 in the same cycle -> rsp dropped, S_IDLE next cycle.
//  6 timeout: TIMEOUT_CYCLES=8, slave never asserts arready -> arvalid held high; o_timeout=1 after 8 cycles; reset clears it.

Source files
------------

// File: rtl/ifetch_axi_lite_master.sv
// Instruction-fetch AXI4-Lite read initiator.
// One fetch in flight at a time: request -> AR -> R -> held response.
// A flush kills the outstanding or held fetch; an in-flight AXI read still
// completes but its beat is dropped. A sticky timeout flag aids bring-up.
module ifetch_axi_lite_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    // core fetch request
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic                  i_flush,
    // core fetch response
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_instr,
    output logic [ADDR_WIDTH-1:0] o_rsp_addr,
    output logic                  o_timeout,
    // AXI4-Lite read channels
    output logic [ADDR_WIDTH-1:0] o_axi_araddr,
    output logic                  o_axi_arvalid,
    input  logic                  i_axi_arready,
    input  logic [DATA_WIDTH-1:0] i_axi_rdata,
    input  logic                  i_axi_rvalid,
    output logic                  o_axi_rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic                  TMO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic                  discard_q, discard_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  in_bus_wait;

    assign in_bus_wait = (state_q == S_AR) || (state_q == S_R);

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            instr_q     <= '0;
            rsp_addr_q  <= '0;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            instr_q     <= instr_d;
            rsp_addr_q  <= rsp_addr_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Fetch sequencing: next state and next register values
    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        instr_d     = instr_q;
        rsp_addr_d  = rsp_addr_q;
        discard_d   = discard_q;

        case (state_q)
            S_IDLE: begin
                // flush has nothing to kill here; a same-cycle request is taken
                if (i_req_valid) begin
                    araddr_d   = i_req_addr & ALIGN_MASK;
                    rsp_addr_d = i_req_addr & ALIGN_MASK;
                    arvalid_d  = 1'b1;
                    state_d    = S_AR;
                end
            end
            S_AR: begin
                if (i_flush) begin
                    discard_d = 1'b1;
                end
                if (i_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (i_flush) begin
                    discard_d = 1'b1;
                end
                if (i_axi_rvalid) begin
                    instr_d  = i_axi_rdata;
                    rready_d = 1'b0;
                    if (discard_q || i_flush) begin
                        discard_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_RSP;
                    end
                end
            end
            S_RSP: begin
                if (i_rsp_ready || i_flush) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating bus-wait counter and sticky timeout flag
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_d == S_IDLE) begin
            cnt_d = '0;
        end else if (in_bus_wait && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (TMO_EN && in_bus_wait && (cnt_d == CNT_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    assign o_req_ready   = (state_q == S_IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_instr   = instr_q;
    assign o_rsp_addr    = rsp_addr_q;
    assign o_timeout     = timeout_q;
    assign o_axi_araddr  = araddr_q;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_rready  = rready_q;

endmodule
